// File: rtl/rx_pkg.sv
// Shared definitions for the Pong link serial receive path: FSM state encoding
// and default frame/oversampling constants.
package rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; resets to the idle-high
// level so a serial line or pulled-up button reads inactive out of reset.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic bounderClock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state uses non-blocking assignments so both flops sample the old values on the same edge.
    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_sequencer.sv
// Receive control FSM: finds the start bit, times mid-bit samples from the
// oversampled tick and strobes the shift/hold datapath one cycle at a time.
module uart_rx_sequencer
    import rx_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic bounderClock,
    input  logic reset,
    input  logic sample_tick,
    input  logic rxbit,
    output logic clear_en,
    output logic shift_en,
    output logic sampled_bit,
    output logic load_en,
    output logic ready,
    output logic framing_error,
    output logic busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    rx_state_t     state, state_n;
    logic [TW-1:0] tick_cnt, tick_n;
    logic [BW-1:0] bit_cnt, bit_n;
    logic          rx_s;
    logic          clear_n, shift_n, sampled_n, load_n, ready_n, ferr_n;

    sync_2ff #(.RESET_VALUE(1'b1)) u_sync (
        .bounderClock (bounderClock),
        .reset        (reset),
        .d            (rxbit),
        .q            (rx_s)
    );

    always_ff @(posedge bounderClock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            clear_en      <= 1'b0;
            shift_en      <= 1'b0;
            sampled_bit   <= 1'b0;
            load_en       <= 1'b0;
            ready         <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            state         <= state_n;
            tick_cnt      <= tick_n;
            bit_cnt       <= bit_n;
            clear_en      <= clear_n;
            shift_en      <= shift_n;
            sampled_bit   <= sampled_n;
            load_en       <= load_n;
            ready         <= ready_n;
            framing_error <= ferr_n;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_n   = state;
        tick_n    = tick_cnt;
        bit_n     = bit_cnt;
        clear_n   = 1'b0;
        shift_n   = 1'b0;
        sampled_n = sampled_bit;
        load_n    = 1'b0;
        ready_n   = 1'b0;
        ferr_n    = 1'b0;

        case (state)
            IDLE: begin
                if (sample_tick && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_cnt == HALF_LAST) begin
                        if (rx_s) begin
                            state_n = IDLE;
                        end else begin
                            clear_n = 1'b1;
                            tick_n  = '0;
                            bit_n   = '0;
                            state_n = DATA;
                        end
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_cnt == FULL_LAST) begin
                        sampled_n = rx_s;
                        shift_n   = 1'b1;
                        tick_n    = '0;
                        bit_n     = bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) state_n = STOP;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is seen on time.
                if (sample_tick) begin
                    if (tick_cnt == FULL_LAST) begin
                        if (rx_s) begin
                            load_n  = 1'b1;
                            ready_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                        tick_n  = '0;
                        state_n = IDLE;
                    end else begin
                        tick_n = tick_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Directed bench for uart_rx_sequencer: drives whole serial frames at 4 clocks
// per tick, 16 ticks per bit, and checks strobe counts and received bytes.
module tb_uart_rx_sequencer;

    logic bounderClock = 1'b0;
    logic reset;
    logic sample_tick;
    logic rxbit;
    logic clear_en, shift_en, sampled_bit, load_en, ready, framing_error, busy;
    logic tick_run = 1'b0;

    int checks   = 0;
    int failures = 0;

    int clear_cnt = 0, shift_cnt = 0, load_cnt = 0, ready_cnt = 0, ferr_cnt = 0;
    int excl_err = 0, rdy_err = 0;
    int s_clear, s_shift, s_load, s_ready, s_ferr;
    logic [7:0] sr_model = '0;
    logic       bit_log  [0:127];
    logic [7:0] load_log [0:15];

    uart_rx_sequencer #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .bounderClock  (bounderClock),
        .reset         (reset),
        .sample_tick   (sample_tick),
        .rxbit         (rxbit),
        .clear_en      (clear_en),
        .shift_en      (shift_en),
        .sampled_bit   (sampled_bit),
        .load_en       (load_en),
        .ready         (ready),
        .framing_error (framing_error),
        .busy          (busy)
    );

    always #5 bounderClock = ~bounderClock;

    // One tick every 4 clocks while tick_run is set.
    initial begin : tick_gen
        logic [1:0] div;
        div = '0;
        sample_tick = 1'b0;
        forever begin
            @(negedge bounderClock);
            if (tick_run) begin
                div = div + 2'd1;
                sample_tick = (div == 2'd0);
            end else begin
                sample_tick = 1'b0;
            end
        end
    end

    // Strobe monitor and shift-register model, sampled on the falling edge.
    always @(negedge bounderClock) begin
        if (clear_en) begin
            clear_cnt++;
            sr_model = '0;
        end
        if (shift_en) begin
            bit_log[shift_cnt[6:0]] = sampled_bit;
            shift_cnt++;
            sr_model = {sampled_bit, sr_model[7:1]};
        end
        if (load_en) begin
            load_log[load_cnt[3:0]] = sr_model;
            load_cnt++;
        end
        if (ready) ready_cnt++;
        if (framing_error) ferr_cnt++;
        if ((32'(clear_en) + 32'(shift_en) + 32'(load_en)) > 1) excl_err++;
        if (ready != load_en) rdy_err++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge bounderClock);
    endtask

    task automatic snap();
        #1;
        s_clear = clear_cnt;
        s_shift = shift_cnt;
        s_load  = load_cnt;
        s_ready = ready_cnt;
        s_ferr  = ferr_cnt;
    endtask

    function automatic logic [7:0] bits_from(input int base);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = bit_log[base + i];
        return r;
    endfunction

    task automatic send_bit(input logic b);
        rxbit = b;
        hold(64);
    endtask

    // Start bit, 8 data bits LSB first, stop bit. A low stop bit is cut short
    // so the re-armed start detector sees it as a glitch. stall_bit >= 0 freezes
    // ticks for 100 clocks a quarter of the way into that data bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int stall_bit);
        int sc, ss, sl, sf;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_bit) begin
                rxbit = d[i];
                hold(16);
                tick_run = 1'b0;
                hold(2);
                #1;
                sc = clear_cnt; ss = shift_cnt; sl = load_cnt; sf = ferr_cnt;
                hold(100);
                #1;
                check("stall_no_strobe", (clear_cnt - sc) + (shift_cnt - ss) + (load_cnt - sl) + (ferr_cnt - sf), 0);
                check("stall_busy", busy, 1);
                tick_run = 1'b1;
                hold(48);
            end else begin
                send_bit(d[i]);
            end
        end
        if (stop) begin
            send_bit(1'b1);
        end else begin
            rxbit = 1'b0;
            hold(48);
            rxbit = 1'b1;
            hold(16);
        end
    endtask

    initial begin
        reset = 1'b1;
        rxbit = 1'b1;
        hold(3);
        #1;
        check("reset_outputs", {busy, clear_en, shift_en, sampled_bit, load_en, ready, framing_error}, 0);
        @(negedge bounderClock);
        reset    = 1'b0;
        tick_run = 1'b1;
        hold(40);
        #1;
        check("idle_not_busy", busy, 0);

        // Frame 0xA5 with a good stop bit.
        snap();
        send_frame(8'hA5, 1'b1, -1);
        hold(40);
        #1;
        check("a5_clear", clear_cnt - s_clear, 1);
        check("a5_shift", shift_cnt - s_shift, 8);
        check("a5_bits", bits_from(s_shift), 8'hA5);
        check("a5_load", load_cnt - s_load, 1);
        check("a5_value", load_log[s_load[3:0]], 8'hA5);
        check("a5_ready", ready_cnt - s_ready, 1);
        check("a5_ferr", ferr_cnt - s_ferr, 0);

        // Start glitch: low for 5 ticks only.
        snap();
        rxbit = 1'b0;
        hold(20);
        rxbit = 1'b1;
        #1;
        check("glitch_busy_mid", busy, 1);
        hold(10);
        #1;
        check("glitch_busy_hold", busy, 1);
        hold(30);
        #1;
        check("glitch_idle", busy, 0);
        check("glitch_no_strobe", (clear_cnt - s_clear) + (shift_cnt - s_shift), 0);
        hold(40);

        // Frame 0x3C with a low stop bit.
        snap();
        send_frame(8'h3C, 1'b0, -1);
        hold(200);
        #1;
        check("3c_shift", shift_cnt - s_shift, 8);
        check("3c_bits", bits_from(s_shift), 8'h3C);
        check("3c_ferr", ferr_cnt - s_ferr, 1);
        check("3c_load", load_cnt - s_load, 0);
        check("3c_ready", ready_cnt - s_ready, 0);
        check("3c_clear", clear_cnt - s_clear, 1);
        check("3c_idle", busy, 0);

        // Reset a quarter of the way into the 4th data bit.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rxbit = 1'b0;
        hold(16);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, clear_en, shift_en, load_en, ready, framing_error}, 0);
        check("rst_mid_partial", shift_cnt - s_shift, 3);
        rxbit = 1'b1;
        hold(4);
        reset = 1'b0;
        hold(80);
        #1;
        check("rst_mid_no_load", load_cnt - s_load, 0);
        snap();
        send_frame(8'h81, 1'b1, -1);
        hold(40);
        #1;
        check("81_value", load_log[s_load[3:0]], 8'h81);
        check("81_ready", ready_cnt - s_ready, 1);

        // Back-to-back 0x55, 0xAA with no idle gap.
        snap();
        send_frame(8'h55, 1'b1, -1);
        send_frame(8'hAA, 1'b1, -1);
        hold(40);
        #1;
        check("b2b_ready", ready_cnt - s_ready, 2);
        check("b2b_shift", shift_cnt - s_shift, 16);
        check("b2b_ferr", ferr_cnt - s_ferr, 0);
        check("b2b_first", load_log[s_load[3:0]], 8'h55);
        check("b2b_second", load_log[4'(s_load + 1)], 8'hAA);

        // Tick stall inside data bit 4 of 0x96.
        snap();
        send_frame(8'h96, 1'b1, 4);
        hold(40);
        #1;
        check("stall_value", load_log[s_load[3:0]], 8'h96);
        check("stall_shift", shift_cnt - s_shift, 8);
        check("stall_ready", ready_cnt - s_ready, 1);

        check("strobe_exclusive", excl_err, 0);
        check("ready_with_load", rdy_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
